// File: rtl/id_stage_pipe.sv
// Pipelined RISC-V instruction-decode stage: register file, immediate generation,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage_pipe #(
    parameter int XLEN    = 64,
    parameter int NREG    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_valid,
    input  logic [31:0]        if_instr,
    input  logic [XLEN-1:0]    if_pc,
    output logic               id_ready,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               ex_stall,
    input  logic               flush,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [RADDR_W-1:0] ex_rs1,
    output logic [RADDR_W-1:0] ex_rs2,
    output logic [RADDR_W-1:0] ex_rd,
    output logic [6:0]         ex_opcode,
    output logic [2:0]         ex_funct3,
    output logic               ex_funct7b5,
    output logic               ex_is_load
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [RADDR_W-1:0] rd;
    logic               is_load;

    assign opcode   = if_instr[6:0];
    assign rd       = if_instr[11:7];
    assign funct3   = if_instr[14:12];
    assign rs1      = if_instr[19:15];
    assign rs2      = if_instr[24:20];
    assign funct7b5 = if_instr[30];
    assign is_load  = (opcode == OP_LOAD);

    // x0 has no storage; it is hardwired to zero by the read ports.
    logic [XLEN-1:0] regs [1:NREG-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    // Write-first read: a same-cycle writeback is forwarded to the operand.
    always_comb begin
        rs1_data = '0;
        if (rs1 == '0) begin
            rs1_data = '0;
        end else if (wb_we && wb_rd == rs1) begin
            rs1_data = wb_data;
        end else begin
            rs1_data = regs[rs1];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2 == '0) begin
            rs2_data = '0;
        end else if (wb_we && wb_rd == rs2) begin
            rs2_data = wb_data;
        end else begin
            rs2_data = regs[rs2];
        end
    end

    imm_fmt_e        imm_fmt;
    logic [XLEN-1:0] imm;

    always_comb begin
        imm_fmt = FMT_NONE;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: imm_fmt = FMT_I;
            OP_STORE:                 imm_fmt = FMT_S;
            OP_BRANCH:                imm_fmt = FMT_B;
            OP_LUI, OP_AUIPC:         imm_fmt = FMT_U;
            OP_JAL:                   imm_fmt = FMT_J;
            default:                  imm_fmt = FMT_NONE;
        endcase
    end

    always_comb begin
        imm = '0;
        case (imm_fmt)
            FMT_I: imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
            FMT_S: imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            FMT_B: imm = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                          if_instr[30:25], if_instr[11:8], 1'b0};
            FMT_U: imm = {{(XLEN-32){if_instr[31]}}, if_instr[31:12], 12'b0};
            FMT_J: imm = {{(XLEN-21){if_instr[31]}}, if_instr[31], if_instr[19:12],
                          if_instr[20], if_instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    logic load_use;
    logic hazard;

    // A load in EX cannot forward its result in time for a dependent instruction in ID.
    assign load_use = ex_valid && ex_is_load && (ex_rd != '0) && ((ex_rd == rs1) || (ex_rd == rs2));
    assign hazard   = if_valid && load_use;
    assign id_ready = !ex_stall && !hazard;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_is_load  <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (!ex_stall) begin
            if (hazard) begin
                ex_valid <= 1'b0;
            end else begin
                ex_valid    <= if_valid;
                ex_pc       <= if_pc;
                ex_rs1_data <= rs1_data;
                ex_rs2_data <= rs2_data;
                ex_imm      <= imm;
                ex_rs1      <= rs1;
                ex_rs2      <= rs2;
                ex_rd       <= rd;
                ex_opcode   <= opcode;
                ex_funct3   <= funct3;
                ex_funct7b5 <= funct7b5;
                ex_is_load  <= is_load;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios followed by randomized
// traffic, compared against a behavioural model built from instruction encodings.
module tb_id_stage_pipe;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        ex_stall;
    logic        flush;
    logic        ex_valid;
    logic [63:0] ex_pc;
    logic [63:0] ex_rs1_data;
    logic [63:0] ex_rs2_data;
    logic [63:0] ex_imm;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        ex_is_load;

    id_stage_pipe #(.XLEN(64), .NREG(32), .RADDR_W(5)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_stall(ex_stall), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
        .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_is_load(ex_is_load)
    );

    always #5 clk = ~clk;

    // Behavioural model state: architectural registers and the expected ID/EX contents.
    logic [63:0] mregs [32];
    bit          m_valid, m_known, m_is_load, m_f7;
    logic [63:0] m_pc, m_r1, m_r2, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [6:0]  m_op;
    logic [2:0]  m_f3;
    longint      cur_imm;
    logic        last_ready;
    bit          exp_ready_last;
    int          errors = 0;
    int          checks = 0;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 64'd0;
        if (wb_we && wb_rd == idx) return wb_data;
        return mregs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
        m_valid = 0; m_known = 1; m_is_load = 0; m_f7 = 0;
        m_pc = 0; m_r1 = 0; m_r2 = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = 0; m_f3 = 0;
    endtask

    // Instruction encoders: the expected immediate is the integer that was encoded.
    task automatic set_i(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [4:0] rs1, input int imm);
        logic [31:0] b;
        b = imm;
        if_instr = {b[11:0], rs1, f3, rd, op};
        cur_imm = longint'(imm);
    endtask

    task automatic set_s(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input int imm);
        logic [31:0] b;
        b = imm;
        if_instr = {b[11:5], rs2, rs1, f3, b[4:0], 7'b0100011};
        cur_imm = longint'(imm);
    endtask

    task automatic set_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input int imm);
        logic [31:0] b;
        b = imm;
        if_instr = {b[12], b[10:5], rs2, rs1, f3, b[4:1], b[11], 7'b1100011};
        cur_imm = longint'(imm);
    endtask

    task automatic set_u(input logic [6:0] op, input logic [4:0] rd, input int imm);
        logic [31:0] b;
        b = imm;
        if_instr = {b[31:12], rd, op};
        cur_imm = longint'(imm);
    endtask

    task automatic set_j(input logic [4:0] rd, input int imm);
        logic [31:0] b;
        b = imm;
        if_instr = {b[20], b[10:1], b[11], b[19:12], rd, 7'b1101111};
        cur_imm = longint'(imm);
    endtask

    task automatic set_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        if_instr = {f7, rs2, rs1, f3, rd, op};
        cur_imm = 0;
    endtask

    // One clock: check id_ready mid-cycle, advance the model at the edge, then check ID/EX.
    task automatic apply_stimulus();
        logic [4:0]  s1, s2;
        logic [63:0] r1, r2;
        bit          hz, rdy;
        s1 = if_instr[19:15];
        s2 = if_instr[24:20];
        hz = if_valid && m_valid && m_is_load && (m_rd != 5'd0) && (m_rd == s1 || m_rd == s2);
        rdy = !ex_stall && !hz;
        @(negedge clk);
        last_ready = id_ready;
        check_output("id_ready", {63'd0, id_ready}, {63'd0, rdy});
        r1 = model_read(s1);
        r2 = model_read(s2);
        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            if (flush) begin
                m_valid = 0; m_known = 0;
            end else if (!ex_stall) begin
                if (hz) begin
                    m_valid = 0; m_known = 0;
                end else begin
                    m_valid = if_valid; m_known = 1;
                    m_pc = if_pc; m_r1 = r1; m_r2 = r2; m_imm = 64'(cur_imm);
                    m_rs1 = s1; m_rs2 = s2; m_rd = if_instr[11:7];
                    m_op = if_instr[6:0]; m_f3 = if_instr[14:12]; m_f7 = if_instr[30];
                    m_is_load = (if_instr[6:0] == OP_LOAD);
                end
            end
            if (wb_we && wb_rd != 5'd0) mregs[wb_rd] = wb_data;
        end
        exp_ready_last = rdy;
        if (rdy) if_pc = if_pc + 64'd4;
        check_output("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
        if (m_known) begin
            check_output("ex_pc", ex_pc, m_pc);
            check_output("ex_rs1_data", ex_rs1_data, m_r1);
            check_output("ex_rs2_data", ex_rs2_data, m_r2);
            check_output("ex_imm", ex_imm, m_imm);
            check_output("ex_rs1", 64'(ex_rs1), 64'(m_rs1));
            check_output("ex_rs2", 64'(ex_rs2), 64'(m_rs2));
            check_output("ex_rd", 64'(ex_rd), 64'(m_rd));
            check_output("ex_opcode", 64'(ex_opcode), 64'(m_op));
            check_output("ex_funct3", 64'(ex_funct3), 64'(m_f3));
            check_output("ex_funct7b5", {63'd0, ex_funct7b5}, {63'd0, m_f7});
            check_output("ex_is_load", {63'd0, ex_is_load}, {63'd0, m_is_load});
        end
    endtask

    task automatic new_random_instr();
        logic [4:0] a, b, d;
        logic [2:0] f3;
        a  = 5'($urandom_range(0, 7));
        b  = 5'($urandom_range(0, 7));
        d  = 5'($urandom_range(0, 7));
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 7))
            0: set_i(OP_LOAD, d, f3, a, int'($urandom_range(0, 4095)) - 2048);
            1: set_i(OP_IMM, d, f3, a, int'($urandom_range(0, 4095)) - 2048);
            2: set_i(OP_JALR, d, 3'd0, a, int'($urandom_range(0, 4095)) - 2048);
            3: set_s(f3, a, b, int'($urandom_range(0, 4095)) - 2048);
            4: set_b(f3, a, b, (int'($urandom_range(0, 4095)) - 2048) * 2);
            5: set_u(($urandom_range(0, 1) != 0) ? OP_LUI : OP_AUIPC, d, int'($urandom & 32'hFFFF_F000));
            6: set_j(d, (int'($urandom_range(0, 1048575)) - 524288) * 2);
            default: set_r(($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, b, a, f3, d,
                           ($urandom_range(0, 3) != 0) ? OP_R : OP_SYS);
        endcase
    endtask

    initial begin
        logic [63:0] snap_pc;
        reset = 1; if_valid = 0; if_instr = 0; if_pc = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0; ex_stall = 0; flush = 0;
        cur_imm = 0; last_ready = 0; exp_ready_last = 1;

        // Reset held two cycles.
        @(posedge clk);
        #1;
        model_reset();
        apply_stimulus();
        check_output("reset_ex_valid", {63'd0, ex_valid}, 64'd0);
        check_output("reset_ex_pc", ex_pc, 64'd0);

        // Read x5 after reset.
        reset = 0; if_valid = 1; if_pc = 64'h1000;
        set_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd1, OP_R);
        apply_stimulus();
        check_output("x5_after_reset", ex_rs1_data, 64'd0);

        // Same-cycle writeback bypass.
        wb_we = 1; wb_rd = 5'd3; wb_data = 64'hA5;
        set_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd1, OP_R);
        apply_stimulus();
        check_output("bypass_x3", ex_rs1_data, 64'hA5);

        // Writes to x0 are discarded.
        wb_rd = 5'd0; wb_data = 64'hFF;
        set_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd1, OP_R);
        apply_stimulus();
        wb_we = 0;
        apply_stimulus();
        check_output("x0_read", ex_rs1_data, 64'd0);

        // Immediate formats.
        set_i(OP_IMM, 5'd1, 3'd0, 5'd0, -1);
        apply_stimulus();
        check_output("imm_addi_m1", ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        set_u(OP_LUI, 5'd1, 32'h1234_5000);
        apply_stimulus();
        check_output("imm_lui", ex_imm, 64'h0000_0000_1234_5000);
        set_b(3'd0, 5'd1, 5'd2, -4);
        apply_stimulus();
        check_output("imm_beq_m4", ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        set_j(5'd1, 2048);
        apply_stimulus();
        check_output("imm_jal_2048", ex_imm, 64'd2048);

        // Load-use hazard: ld x2 then add x4,x2,x1.
        set_i(OP_LOAD, 5'd2, 3'd3, 5'd1, 0);
        apply_stimulus();
        set_r(7'h00, 5'd1, 5'd2, 3'd0, 5'd4, OP_R);
        apply_stimulus();
        check_output("hazard_ready", {63'd0, last_ready}, 64'd0);
        check_output("hazard_bubble", {63'd0, ex_valid}, 64'd0);
        apply_stimulus();
        check_output("hazard_issue_ready", {63'd0, last_ready}, 64'd1);
        check_output("hazard_issue_valid", {63'd0, ex_valid}, 64'd1);
        check_output("hazard_issue_rs1", 64'(ex_rs1), 64'd2);

        // Downstream stall holds ID/EX, then flush wins over stall.
        set_i(OP_IMM, 5'd7, 3'd0, 5'd1, 5);
        snap_pc = if_pc;
        apply_stimulus();
        ex_stall = 1;
        set_r(7'h20, 5'd3, 5'd4, 3'd5, 5'd9, OP_R);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus();
            check_output("stall_ready", {63'd0, last_ready}, 64'd0);
            check_output("stall_pc", ex_pc, snap_pc);
            check_output("stall_rd", 64'(ex_rd), 64'd7);
        end
        flush = 1;
        apply_stimulus();
        check_output("flush_over_stall", {63'd0, ex_valid}, 64'd0);
        flush = 0; ex_stall = 0;

        // Randomized traffic; IF holds its instruction whenever ID is not ready.
        for (int n = 0; n < 400; n++) begin
            if (exp_ready_last) new_random_instr();
            if_valid = ($urandom_range(0, 7) != 0);
            wb_we    = ($urandom_range(0, 1) != 0);
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = {$urandom, $urandom};
            ex_stall = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 49) == 0);
            apply_stimulus();
        end
        reset = 0;

        $display("[TB] stimulus complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
